// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: walks a 32-bit nonce range through the SHA-256 double-hash
// core, compares each result's top TGT_W bits against a latched target and
// stops on the first win or when the inclusive range (which may wrap) is done.
// Optional build macro: SCHED_TIMEOUT_EN adds a WAIT watchdog that routes a
// hung core to the ERROR state after TIMEOUT_CYC cycles.
`timescale 1ns/1ps

module sha256_nonce_sched #(
  parameter int unsigned TGT_W       = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      nonce_first,
  input  logic [31:0]      nonce_last,
  input  logic [TGT_W-1:0] target,
  input  logic             core_ready,
  output logic             core_start,
  output logic [31:0]      core_nonce,
  input  logic             core_done,
  input  logic [TGT_W-1:0] core_hash_top,
  output logic             busy,
  output logic             found,
  output logic [31:0]      found_nonce,
  output logic             exhausted,
  output logic [CNT_W-1:0] tried,
  output logic [3:0]       status
);

  localparam int unsigned NONCE_W = 32;

  // Encodings double as the exported status code.
  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    ISSUE     = 4'h1,
    WAIT      = 4'h2,
    CHECK     = 4'h3,
    EXHAUSTED = 4'h5,
    FOUND     = 4'hA,
    ERROR     = 4'hE
  } state_e;

  state_e             state_q;
  logic [NONCE_W-1:0] cur_q;
  logic [NONCE_W-1:0] end_q;
  logic [TGT_W-1:0]   target_q;
  logic [TGT_W-1:0]   hash_q;
  logic               abort_q;
  logic               core_start_q;
  logic [NONCE_W-1:0] core_nonce_q;
  logic               busy_q;
  logic               found_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic               exhausted_q;
  logic [CNT_W-1:0]   tried_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
`endif

  // Scheduler FSM with all outputs held in registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      end_q         <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      abort_q       <= 1'b0;
      core_start_q  <= 1'b0;
      core_nonce_q  <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      exhausted_q   <= 1'b0;
      tried_q       <= '0;
`ifdef SCHED_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        // Resting states: stop clears the result, start (without stop) launches a run.
        IDLE, FOUND, EXHAUSTED, ERROR: begin
          if (stop) begin
            state_q     <= IDLE;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
          end else if (start) begin
            state_q     <= ISSUE;
            cur_q       <= nonce_first;
            end_q       <= nonce_last;
            target_q    <= target;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            tried_q     <= '0;
            busy_q      <= 1'b1;
          end
        end

        ISSUE: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (core_ready) begin
            state_q      <= WAIT;
            core_start_q <= 1'b1;
            core_nonce_q <= cur_q;
            abort_q      <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            wdog_q       <= '0;
`endif
          end
        end

        // The core is always allowed to finish; an abort only discards the result.
        WAIT: begin
          if (core_done) begin
            if (abort_q || stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CHECK;
              hash_q  <= core_hash_top;
            end
          end else begin
            if (stop) begin
              abort_q <= 1'b1;
            end
`ifdef SCHED_TIMEOUT_EN
            if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
              state_q     <= ERROR;
              busy_q      <= 1'b0;
              found_q     <= 1'b0;
              exhausted_q <= 1'b0;
            end else begin
              wdog_q <= wdog_q + WD_W'(1);
            end
`endif
          end
        end

        CHECK: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (tried_q != '1) begin
              tried_q <= tried_q + CNT_W'(1);
            end
            if (hash_q < target_q) begin
              state_q       <= FOUND;
              found_q       <= 1'b1;
              found_nonce_q <= cur_q;
              busy_q        <= 1'b0;
            end else if (cur_q == end_q) begin
              state_q     <= EXHAUSTED;
              exhausted_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= ISSUE;
              cur_q   <= cur_q + NONCE_W'(1);
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_start  = core_start_q;
  assign core_nonce  = core_nonce_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign exhausted   = exhausted_q;
  assign tried       = tried_q;
  assign status      = state_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed bench for sha256_nonce_sched with a behavioural hash core and a
// scoreboard of expected issue nonces.
`timescale 1ns/1ps

module tb_sha256_nonce_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [31:0] target = '0;
  logic        core_ready;
  logic        core_start;
  logic [31:0] core_nonce;
  logic        core_done = 1'b0;
  logic [31:0] core_hash_top = '0;
  logic        busy;
  logic        found;
  logic [31:0] found_nonce;
  logic        exhausted;
  logic [31:0] tried;
  logic [3:0]  status;

  int n_tests = 0;
  int n_fail  = 0;

  // Core model controls
  bit          ready_en = 1'b1;
  bit          respond  = 1'b1;
  bit          win_en   = 1'b0;
  logic [31:0] win_nonce = '0;
  int          lat = 8;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] cur_n = '0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign core_ready = ready_en && !pending;

  sha256_nonce_sched #(.TGT_W(32), .CNT_W(32), .TIMEOUT_CYC(16)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start        (start),
    .stop         (stop),
    .nonce_first  (nonce_first),
    .nonce_last   (nonce_last),
    .target       (target),
    .core_ready   (core_ready),
    .core_start   (core_start),
    .core_nonce   (core_nonce),
    .core_done    (core_done),
    .core_hash_top(core_hash_top),
    .busy         (busy),
    .found        (found),
    .found_nonce  (found_nonce),
    .exhausted    (exhausted),
    .tried        (tried),
    .status       (status)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural hash core: checks each issue against the scoreboard, answers after lat cycles.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (pending) begin
      if (status == 4'h2) chk("nonce_stable", core_nonce, cur_n);
      if (cnt <= 1) begin
        if (respond) begin
          core_done     = 1'b1;
          core_hash_top = (win_en && cur_n == win_nonce) ? 32'h0 : 32'hFFFF_FFF0;
        end
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (core_start === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_core_start", 1, 0);
      else chk("core_nonce", core_nonce, exp_q.pop_front());
      pending = 1'b1;
      cnt     = lat;
      cur_n   = core_nonce;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + 32'd1;
    end
  endtask

  // Launch a run, then scramble the range/target to prove they were latched.
  task automatic run(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t);
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    nonce_first = $urandom;
    nonce_last  = $urandom;
    target      = $urandom;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k = 0;
    while (busy === 1'b1 && k < maxc) begin
      tick();
      k++;
    end
    chk({tag, "_not_busy"}, busy, 0);
  endtask

  task automatic wait_start(input logic [31:0] n, input int maxc, input string tag);
    int k = 0;
    while (!(core_start === 1'b1 && core_nonce === n) && k < maxc) begin
      tick();
      k++;
    end
    chk({tag, "_issue_seen"}, core_start, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_status"}, status, 4'h0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_nonce"}, core_nonce, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_found_nonce"}, found_nonce, 0);
    chk({tag, "_exhausted"}, exhausted, 0);
    chk({tag, "_tried"}, tried, 0);
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Range 10..13, target 0, slow core: exhausts after four nonces
    lat = 64;
    push_range(32'd10, 4);
    run(32'd10, 32'd13, 32'd0);
    chk("t1_busy", busy, 1);
    chk("t1_status_issue", status, 4'h1);
    wait_idle(2000, "t1");
    chk("t1_tried", tried, 4);
    chk("t1_exhausted", exhausted, 1);
    chk("t1_status", status, 4'h5);
    chk("t1_found", found, 0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Range 100..200 with a single winner at 105
    lat = 8;
    win_en = 1'b1;
    win_nonce = 32'd105;
    push_range(32'd100, 6);
    run(32'd100, 32'd200, 32'h0000_1000);
    wait_idle(2000, "t2");
    chk("t2_found", found, 1);
    chk("t2_found_nonce", found_nonce, 105);
    chk("t2_tried", tried, 6);
    chk("t2_status", status, 4'hA);
    chk("t2_exhausted", exhausted, 0);
    repeat (20) tick();
    chk("t2_status_held", status, 4'hA);
    chk("t2_queue_empty", exp_q.size(), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_status", status, 4'h0);
    chk("t2_stop_found", found, 0);
    win_en = 1'b0;

    // Wrapping range FFFFFFFE..1
    push_range(32'hFFFF_FFFE, 4);
    run(32'hFFFF_FFFE, 32'd1, 32'd0);
    wait_idle(2000, "t3");
    chk("t3_tried", tried, 4);
    chk("t3_exhausted", exhausted, 1);
    chk("t3_status", status, 4'h5);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Stop during WAIT of nonce 7: result discarded after core_done
    lat = 64;
    push_range(32'd5, 3);
    run(32'd5, 32'd20, 32'd0);
    wait_start(32'd7, 2000, "t4");
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_still_wait", status, 4'h2);
    chk("t4_busy_wait", busy, 1);
    begin
      int k = 0;
      while (core_done !== 1'b1 && k < 200) begin
        chk("t4_wait_until_done", status, 4'h2);
        tick();
        k++;
      end
    end
    chk("t4_done_seen", core_done, 1);
    chk("t4_idle", status, 4'h0);
    chk("t4_busy", busy, 0);
    chk("t4_tried", tried, 2);
    chk("t4_exhausted", exhausted, 0);
    repeat (10) tick();
    chk("t4_queue_empty", exp_q.size(), 0);
    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t4_ss_status", status, 4'h0);
    chk("t4_ss_busy", busy, 0);
    tick();
    chk("t4_ss_status2", status, 4'h0);

    // core_ready low for 20 cycles in ISSUE, single-nonce range
    lat = 8;
    ready_en = 1'b0;
    push_range(32'd50, 1);
    run(32'd50, 32'd50, 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("t5_no_start", core_start, 0);
      chk("t5_in_issue", status, 4'h1);
      tick();
    end
    ready_en = 1'b1;
    tick();
    chk("t5_pulse", core_start, 1);
    tick();
    chk("t5_pulse_end", core_start, 0);
    wait_idle(500, "t5");
    chk("t5_tried", tried, 1);
    chk("t5_exhausted", exhausted, 1);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Reset in the middle of WAIT; the late core_done must be ignored
    lat = 64;
    push_range(32'd300, 1);
    run(32'd300, 32'd400, 32'd0);
    wait_start(32'd300, 500, "t6");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_reset("t6_midrst");
    rst = 1'b0;
    repeat (80) tick();
    chk("t6_idle_after_done", status, 4'h0);
    chk("t6_tried", tried, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

`ifdef SCHED_TIMEOUT_EN
    // Core never answers: ERROR after 16 WAIT cycles, then a clean restart
    lat = 8;
    respond = 1'b0;
    push_range(32'd33, 1);
    run(32'd33, 32'd40, 32'd0);
    wait_start(32'd33, 500, "t7");
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t7_waiting", status, 4'h2);
    end
    tick();
    chk("t7_error", status, 4'hE);
    chk("t7_busy", busy, 0);
    chk("t7_found", found, 0);
    chk("t7_exhausted", exhausted, 0);
    respond = 1'b1;
    repeat (5) tick();
    chk("t7_error_held", status, 4'hE);
    push_range(32'd33, 8);
    run(32'd33, 32'd40, 32'd0);
    wait_idle(1000, "t7r");
    chk("t7r_exhausted", exhausted, 1);
    chk("t7r_tried", tried, 8);
    chk("t7r_queue_empty", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
